// File: rtl/edge_pkg.sv
// Types and defaults shared across the edge-detection pipeline stages.
package edge_pkg;

  typedef enum logic [1:0] {
    ANG_0   = 2'd0,
    ANG_45  = 2'd1,
    ANG_90  = 2'd2,
    ANG_135 = 2'd3
  } angle_e;

  localparam int unsigned DEF_WIDTH  = 18;
  localparam int unsigned DEF_HEIGHT = 18;
  localparam int unsigned DEF_MAG_W  = 5;

  typedef struct packed {
    logic [DEF_MAG_W-1:0] mag;
    angle_e               ang;
  } pixel_t;

endpackage

// File: rtl/nms_line_buffer.sv
// Enable-gated shift register holding one image row of {mag, ang} entries.
module nms_line_buffer #(
  parameter int unsigned DEPTH  = 18,
  parameter int unsigned DATA_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/nms_stage.sv
// Non-maximum suppression: thins the Sobel magnitude stream along the
// quantised gradient direction, emitting only interior pixels.
module nms_stage
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned MAG_W  = DEF_MAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [1:0]       in_ang,
  output logic             out_valid,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_last
);

  localparam int unsigned PIX_W = MAG_W + 2;
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;
  logic             row_end;

  assign col_end = (col == COL_W'(WIDTH - 1));
  assign row_end = (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] lb1_out;
  logic [PIX_W-1:0] lb2_out;

  assign pix_in = {in_mag, in_ang};

  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid),
    .din   (pix_in),
    .dout  (lb1_out)
  );

  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb2 (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid),
    .din   (lb1_out),
    .dout  (lb2_out)
  );

  // The 3x3 window is two registered columns (c-2, c-1) plus the live
  // column c, so the decision for centre (r-1,c-1) lands on the edge
  // that accepts (r,c). Rows: 0 = r-2 (N), 1 = r-1, 2 = r (S).
  logic [PIX_W-1:0] win [3][2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned y = 0; y < 3; y++) begin
        win[y][0] <= '0;
        win[y][1] <= '0;
      end
    end else if (in_valid) begin
      for (int unsigned y = 0; y < 3; y++) win[y][0] <= win[y][1];
      win[0][1] <= lb2_out;
      win[1][1] <= lb1_out;
      win[2][1] <= pix_in;
    end
  end

  logic [MAG_W-1:0] vmag [3][3];
  logic [MAG_W-1:0] centre;
  logic [MAG_W-1:0] nb_a;
  logic [MAG_W-1:0] nb_b;
  logic             keep;
  logic             emit;
  logic             unused_ang;

  assign unused_ang = ^{win[0][0][1:0], win[1][0][1:0], win[2][0][1:0]};

  always_comb begin
    for (int unsigned y = 0; y < 3; y++) begin
      vmag[y][0] = win[y][0][PIX_W-1:2];
      vmag[y][1] = win[y][1][PIX_W-1:2];
    end
    vmag[0][2] = lb2_out[PIX_W-1:2];
    vmag[1][2] = lb1_out[PIX_W-1:2];
    vmag[2][2] = in_mag;

    centre = vmag[1][1];
    nb_a   = '0;
    nb_b   = '0;
    case (angle_e'(win[1][1][1:0]))
      ANG_0:   begin nb_a = vmag[1][0]; nb_b = vmag[1][2]; end
      ANG_45:  begin nb_a = vmag[0][2]; nb_b = vmag[2][0]; end
      ANG_90:  begin nb_a = vmag[0][1]; nb_b = vmag[2][1]; end
      ANG_135: begin nb_a = vmag[0][0]; nb_b = vmag[2][2]; end
      default: begin nb_a = '0;         nb_b = '0;         end
    endcase
    keep = (centre >= nb_a) && (centre >= nb_b);
    emit = in_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_last  <= emit && row_end && col_end;
      if (emit) out_mag <= keep ? centre : '0;
    end
  end

endmodule

// File: tb/tb_nms_stage.sv
// Self-checking bench for nms_stage: pattern table plus randomized frames
// against a 2-D array reference model, and reset corner sequences.
module tb_nms_stage;

  localparam int W  = 18;
  localparam int H  = 18;
  localparam int MW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [MW-1:0] in_mag = '0;
  logic [1:0]    in_ang = '0;
  logic          out_valid;
  logic [MW-1:0] out_mag;
  logic          out_last;

  always #5 clk = ~clk;

  nms_stage #(.WIDTH(W), .HEIGHT(H), .MAG_W(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_mag    (in_mag),
    .in_ang    (in_ang),
    .out_valid (out_valid),
    .out_mag   (out_mag),
    .out_last  (out_last)
  );

  int checks = 0;
  int failures = 0;

  int img_mag [H][W];
  int img_ang [H][W];
  int held_mag = 0;
  int n_out, n_nz, sum_out, first_nz, n_last;

  // pat: 0 flat 10, 1 single peak, 2 ramp col, 3 diag row+col (wraps at 32),
  //      4 random. ang 4 = random per pixel. stall: 0 none, 1 random, 3 every third.
  // Negative expectations mean "model-only".
  typedef struct {
    int pat;
    int ang;
    int stall;
    int exp_count;
    int exp_nz;
    int exp_sum;
    int exp_first_nz;
  } vec_t;

  vec_t tbl [9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_nms(int r, int c);
    int dr, dc, m, a, b;
    case (img_ang[r][c])
      0:       begin dr = 0;  dc = -1; end
      1:       begin dr = -1; dc = 1;  end
      2:       begin dr = -1; dc = 0;  end
      default: begin dr = -1; dc = -1; end
    endcase
    m = img_mag[r][c];
    a = img_mag[r+dr][c+dc];
    b = img_mag[r-dr][c-dc];
    return (m >= a && m >= b) ? m : 0;
  endfunction

  task automatic fill_image(int pat, int ang);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (pat)
          0: img_mag[r][c] = 10;
          1: img_mag[r][c] = (r == 5 && c == 5) ? 20 : 0;
          2: img_mag[r][c] = c;
          3: img_mag[r][c] = (r + c) % 32;
          default: img_mag[r][c] = $urandom_range(0, 31);
        endcase
        img_ang[r][c] = (ang == 4) ? $urandom_range(0, 3) : ang;
      end
  endtask

  task automatic step(bit v, int r, int c);
    bit ev, el;
    int em;
    @(negedge clk);
    in_valid = v;
    in_mag   = v ? MW'(img_mag[r][c]) : MW'($urandom);
    in_ang   = v ? 2'(img_ang[r][c])  : 2'($urandom);
    ev = v && r >= 2 && c >= 2;
    el = ev && r == H-1 && c == W-1;
    if (ev) begin
      em = ref_nms(r-1, c-1);
      held_mag = em;
    end else begin
      em = held_mag;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, ev);
    check("out_last", out_last, el);
    check("out_mag", out_mag, em);
    if (out_valid === 1'b1) begin
      if (out_mag != 0 && first_nz < 0) first_nz = n_out;
      if (out_mag != 0) n_nz++;
      sum_out += out_mag;
      if (out_last === 1'b1) n_last++;
      n_out++;
    end
  endtask

  task automatic run_frame(int stall);
    int cyc = 0;
    n_out = 0; n_nz = 0; sum_out = 0; first_nz = -1; n_last = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if ((stall == 3 && cyc % 3 == 2) || (stall == 1 && $urandom_range(0, 3) == 0)) begin
          step(0, 0, 0);
          cyc++;
        end
        step(1, r, c);
        cyc++;
      end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 256, 256, 2560, 0};
    tbl[1] = '{1, 2, 0, 256, 1, 20, 68};
    tbl[2] = '{2, 0, 0, 256, 0, 0, -1};
    tbl[3] = '{2, 2, 0, 256, 256, 2176, 0};
    tbl[4] = '{3, 3, 0, 256, 5, 152, 223};
    tbl[5] = '{3, 1, 0, 256, 255, 4320, 0};
    tbl[6] = '{0, 0, 3, 256, 256, 2560, 0};
    tbl[7] = '{4, 4, 1, 256, -1, -1, -2};
    tbl[8] = '{4, 4, 0, 256, -1, -1, -2};

    // Reset held low: outputs stay zero, then idle cycles after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_mag", out_mag, 0);
      check("rst_last", out_last, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Back-to-back frames from the table.
    foreach (tbl[i]) begin
      fill_image(tbl[i].pat, tbl[i].ang);
      run_frame(tbl[i].stall);
      check("frame_count", n_out, tbl[i].exp_count);
      check("frame_last_count", n_last, 1);
      if (tbl[i].exp_nz >= 0) check("frame_nonzero", n_nz, tbl[i].exp_nz);
      if (tbl[i].exp_sum >= 0) check("frame_sum", sum_out, tbl[i].exp_sum);
      if (tbl[i].exp_first_nz >= -1) check("frame_first_nz", first_nz, tbl[i].exp_first_nz);
    end

    // Mid-frame reset: outputs drop asynchronously, next pixel is (0,0).
    fill_image(0, 0);
    n_out = 0; n_nz = 0; sum_out = 0; first_nz = -1; n_last = 0;
    for (int i = 0; i < 100; i++) step(1, i / W, i % W);
    check("pre_reset_valid", out_valid, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_mag", out_mag, 0);
    check("async_rst_last", out_last, 0);
    held_mag = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_frame(0);
    check("post_reset_count", n_out, 256);
    check("post_reset_last", n_last, 1);
    check("post_reset_sum", sum_out, 2560);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
